// File: rtl/falling_spawn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : falling_spawn_pkg
//  Description : Shared types, LFSR tap mask and round-robin slot picker for
//                the falling-object spawn scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package falling_spawn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_SPAWN = 3'd3,
        S_DRAIN = 3'd4
    } spawn_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Unused slots above the pool size must be passed in as occupied; the
    // modulo-8 scan order then matches a scan that wraps at the pool size.
    function automatic pick_t pick_free_rr(input logic [7:0] visible, input logic [2:0] ptr);
        pick_t      r;
        logic [2:0] k;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            k = ptr + 3'(i);
            if (!r.found && !visible[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_lfsr16
//  Description : 16-bit Fibonacci LFSR with synchronous seed load and step.
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_lfsr16
    import falling_spawn_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] r_value;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_value <= RESET_VALUE;
        end else if (seed_load) begin
            r_value <= seed;
        end else if (step) begin
            r_value <= {r_value[14:0], ^(r_value & c_lfsr_taps)};
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/falling_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : falling_spawn_scheduler
//  Description : Shared spawn controller: random gap timer, leap-zone X
//                shaping and round-robin allocation over a pool of movers.
//  Revision    : 1.0 - initial release
// ============================================================================
module falling_spawn_scheduler
    import falling_spawn_pkg::*;
#(
    parameter int          NUM_SLOTS            = 4,
    parameter int          MIN_TIME_TO_REAPPEAR = 5,
    parameter int          MAX_TIME_TO_REAPPEAR = 20,
    parameter int          MIN_X                = 48,
    parameter int          MAX_X                = 592,
    parameter int          LEAP_START           = 272,
    parameter int          LEAP_END             = 336,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 oneTensSec,
    input  logic                 startofLevel,
    input  logic                 endLevel,
    input  logic                 enable,
    input  logic [3:0]           seedindex,
    input  logic [31:0]          objectSpeed,
    input  logic [NUM_SLOTS-1:0] exceed,
    output logic [NUM_SLOTS-1:0] loadX,
    output logic [10:0]          topLeftX,
    output logic [NUM_SLOTS-1:0] visible,
    output logic [31:0]          speed,
    output logic                 busy
);

    localparam int c_tw      = $clog2(MAX_TIME_TO_REAPPEAR + 1);
    localparam int c_range_t = MAX_TIME_TO_REAPPEAR - MIN_TIME_TO_REAPPEAR + 1;
    localparam int c_range_x = MAX_X - MIN_X + 1;

    spawn_state_t         r_state, w_next_state;
    logic [c_tw-1:0]      r_timer;
    logic [2:0]           r_rr_ptr;
    logic [NUM_SLOTS-1:0] r_visible;
    logic [NUM_SLOTS-1:0] r_loadX;
    logic [10:0]          r_topLeftX;
    logic [31:0]          r_speed;
    logic                 r_busy;

    logic [15:0]          w_lfsr;
    logic                 w_seed_load;
    logic                 w_step;
    logic                 w_arm;
    logic                 w_spawn;
    logic                 w_drain_done;
    logic [7:0]           w_vis8;
    pick_t                w_pick;
    logic [NUM_SLOTS-1:0] w_onehot;
    logic [2:0]           w_ptr_next;
    logic [10:0]          w_x_raw;
    logic [10:0]          w_x;
    logic [c_tw-1:0]      w_timer_init;

    spawn_lfsr16 #(
        .RESET_VALUE (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .resetN    (resetN),
        .seed_load (w_seed_load),
        .seed      (LFSR_SEED ^ {seedindex, 12'h000}),
        .step      (w_step),
        .value     (w_lfsr)
    );

    always_comb begin
        w_vis8                  = '1;
        w_vis8[NUM_SLOTS-1:0]   = r_visible;
        w_pick                  = pick_free_rr(w_vis8, r_rr_ptr);
        w_onehot                = NUM_SLOTS'(1) << w_pick.idx;
        w_ptr_next              = (w_pick.idx == 3'(NUM_SLOTS - 1)) ? 3'd0 : w_pick.idx + 3'd1;
        w_x_raw                 = 11'(MIN_X) + ({1'b0, w_lfsr[9:0]} % 11'(c_range_x));
        // Objects never land in the leap window; push them just past it.
        w_x                     = (w_x_raw >= 11'(LEAP_START) && w_x_raw < 11'(LEAP_END))
                                  ? 11'(LEAP_END) : w_x_raw;
        w_timer_init            = c_tw'(MIN_TIME_TO_REAPPEAR) + c_tw'(w_lfsr % 16'(c_range_t));
        w_drain_done            = (r_visible == '0);
    end

    always_comb begin
        w_next_state = r_state;
        w_seed_load  = 1'b0;
        w_step       = 1'b0;
        w_arm        = 1'b0;
        w_spawn      = 1'b0;
        if (startofLevel) begin
            w_seed_load  = 1'b1;
            w_next_state = S_ARM;
        end else begin
            case (r_state)
                S_IDLE: w_next_state = S_IDLE;
                S_ARM: begin
                    if (endLevel) begin
                        w_next_state = S_DRAIN;
                    end else begin
                        w_arm        = 1'b1;
                        w_step       = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (endLevel) begin
                        w_next_state = S_DRAIN;
                    end else if (r_timer == '0 && enable && w_pick.found) begin
                        w_spawn      = 1'b1;
                        w_next_state = S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    w_step       = 1'b1;
                    w_next_state = endLevel ? S_DRAIN : S_ARM;
                end
                S_DRAIN: begin
                    if (w_drain_done) w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // The load pulse is registered on the WAIT->SPAWN edge so it is high
    // throughout the SPAWN cycle together with the new X and visible bit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_rr_ptr   <= 3'd0;
            r_visible  <= '0;
            r_loadX    <= '0;
            r_topLeftX <= '0;
            r_speed    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_loadX <= '0;
            if (w_arm) begin
                r_timer <= w_timer_init;
            end else if (r_state == S_WAIT && oneTensSec && enable && r_timer != '0) begin
                r_timer <= r_timer - c_tw'(1);
            end
            if (startofLevel) begin
                r_speed   <= objectSpeed;
                r_visible <= '0;
            end else begin
                r_visible <= (r_visible & ~exceed) | (w_spawn ? w_onehot : '0);
                if (w_spawn) begin
                    r_loadX    <= w_onehot;
                    r_topLeftX <= w_x;
                    r_rr_ptr   <= w_ptr_next;
                end
                if (r_state == S_DRAIN && w_drain_done) r_speed <= '0;
            end
        end
    end

    assign loadX    = r_loadX;
    assign topLeftX = r_topLeftX;
    assign visible  = r_visible;
    assign speed    = r_speed;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_falling_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_falling_spawn_scheduler
//  Description : Self-checking bench for falling_spawn_scheduler with a
//                behavioural reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_falling_spawn_scheduler;

    logic        clk;
    logic        resetN;
    logic        oneTensSec;
    logic        startofLevel;
    logic        endLevel;
    logic        enable;
    logic [3:0]  seedindex;
    logic [31:0] objectSpeed;
    logic [3:0]  exceed;
    logic [3:0]  loadX;
    logic [10:0] topLeftX;
    logic [3:0]  visible;
    logic [31:0] speed;
    logic        busy;

    falling_spawn_scheduler u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .oneTensSec   (oneTensSec),
        .startofLevel (startofLevel),
        .endLevel     (endLevel),
        .enable       (enable),
        .seedindex    (seedindex),
        .objectSpeed  (objectSpeed),
        .exceed       (exceed),
        .loadX        (loadX),
        .topLeftX     (topLeftX),
        .visible      (visible),
        .speed        (speed),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_ARM, P_WAIT, P_SPAWN, P_DRAIN} phase_t;
    phase_t      m_phase = P_IDLE;
    int unsigned m_lfsr  = 16'hACE1;
    int          m_timer = 0;
    int          m_rr    = 0;
    logic [3:0]  m_vis   = '0;
    logic [3:0]  m_load  = '0;
    int          m_x     = 0;
    logic [31:0] m_speed = '0;
    logic        m_busy  = 1'b0;

    function automatic int unsigned lfsr_next(input int unsigned v);
        logic [15:0] b;
        logic        fb;
        b  = v[15:0];
        fb = b[15] ^ b[13] ^ b[12] ^ b[10];
        return {16'h0, b[14:0], fb};
    endfunction

    function automatic int spawn_x(input int unsigned v);
        int x;
        x = 48 + int'((v & 1023) % 545);
        if (x >= 272 && x < 336) x = 336;
        return x;
    endfunction

    always @(posedge clk) begin
        logic [3:0] nvis;
        int         s;
        if (!resetN) begin
            m_phase = P_IDLE; m_lfsr = 16'hACE1; m_timer = 0; m_rr = 0;
            m_vis = '0; m_load = '0; m_x = 0; m_speed = '0; m_busy = 1'b0;
        end else begin
            nvis   = m_vis & ~exceed;
            m_load = '0;
            if (startofLevel) begin
                m_lfsr  = 32'(16'hACE1 ^ {seedindex, 12'h000});
                m_speed = objectSpeed;
                nvis    = '0;
                m_phase = P_ARM;
            end else begin
                case (m_phase)
                    P_ARM: begin
                        if (endLevel) m_phase = P_DRAIN;
                        else begin
                            m_timer = 5 + int'(m_lfsr % 16);
                            m_lfsr  = lfsr_next(m_lfsr);
                            m_phase = P_WAIT;
                        end
                    end
                    P_WAIT: begin
                        if (endLevel) m_phase = P_DRAIN;
                        else if (m_timer == 0 && enable && m_vis != 4'hF) begin
                            s = -1;
                            for (int k = 0; k < 4; k++)
                                if (s < 0 && !m_vis[(m_rr + k) % 4]) s = (m_rr + k) % 4;
                            m_load  = 4'(1 << s);
                            nvis    = nvis | m_load;
                            m_x     = spawn_x(m_lfsr);
                            m_rr    = (s + 1) % 4;
                            m_phase = P_SPAWN;
                        end else if (oneTensSec && enable && m_timer > 0) begin
                            m_timer--;
                        end
                    end
                    P_SPAWN: begin
                        m_lfsr  = lfsr_next(m_lfsr);
                        m_phase = endLevel ? P_DRAIN : P_ARM;
                    end
                    P_DRAIN: begin
                        if (m_vis == '0) begin
                            m_phase = P_IDLE;
                            m_speed = '0;
                        end
                    end
                    default: ;
                endcase
            end
            m_vis  = nvis;
            m_busy = (m_phase != P_IDLE);
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_loadX",    32'(loadX),    32'(m_load));
            check("cyc_topLeftX", 32'(topLeftX), 32'(m_x));
            check("cyc_visible",  32'(visible),  32'(m_vis));
            check("cyc_speed",    speed,         m_speed);
            check("cyc_busy",     32'(busy),     32'(m_busy));
        end
    end

    // ---------------- tick generator ----------------
    bit tick_rand = 1'b0;
    int tick_div  = 0;
    int tick_cnt  = 0;
    always @(negedge clk) begin
        if (tick_rand) oneTensSec = ($urandom_range(0, 2) == 0);
        else begin
            tick_div   = (tick_div + 1) % 4;
            oneTensSec = (tick_div == 0);
        end
    end
    always @(posedge clk) if (oneTensSec) tick_cnt++;

    // ---------------- helpers ----------------
    task automatic wait_load(input int limit, output logic [3:0] l, output logic [10:0] x);
        bit got;
        got = 1'b0; l = '0; x = '0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (loadX != '0) begin
                got = 1'b1; l = loadX; x = topLeftX;
            end
        end
        check("load_within_bound", 32'(got), 32'd1);
    endtask

    task automatic count_loads(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (loadX != '0) n++;
        end
    endtask

    task automatic pulse_exceed(input logic [3:0] m);
        exceed = m;
        @(negedge clk);
        exceed = '0;
    endtask

    task automatic start_level(input logic [3:0] si, input logic [31:0] spd);
        seedindex    = si;
        objectSpeed  = spd;
        startofLevel = 1'b1;
        @(negedge clk);
        startofLevel = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  l;
        logic [10:0] x, x_first;
        int          n, t0;

        resetN = 1'b0; startofLevel = 1'b0; endLevel = 1'b0; enable = 1'b1;
        seedindex = '0; objectSpeed = '0; exceed = '0; oneTensSec = 1'b0;

        check("model_lfsr_step", lfsr_next(32'hACE1), 32'h59C3);
        check("model_x_leap",    32'(spawn_x(252)),   32'd336);
        check("model_x_min",     32'(spawn_x(0)),     32'd48);
        check("model_x_wrap",    32'(spawn_x(1023)),  32'd526);

        repeat (3) @(negedge clk);
        check("rst_loadX", 32'(loadX), 0);
        check("rst_topLeftX", 32'(topLeftX), 0);
        check("rst_visible", 32'(visible), 0);
        check("rst_speed", speed, 0);
        check("rst_busy", 32'(busy), 0);
        resetN = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        t0 = tick_cnt;
        start_level(4'd0, 32'd3);
        check("start_busy", 32'(busy), 1);
        check("start_speed", speed, 3);
        wait_load(400, l, x);
        check("first_load", 32'(l), 32'b0001);
        check("first_x", 32'(x), 32'd499);
        check("first_gap_ticks", 32'((tick_cnt - t0) >= 5 && (tick_cnt - t0) <= 21), 1);
        check("first_x_legal", 32'(x >= 48 && x <= 592 && !(x >= 272 && x < 336)), 1);

        wait_load(400, l, x); check("load_2", 32'(l), 32'b0010);
        wait_load(400, l, x); check("load_3", 32'(l), 32'b0100);
        wait_load(400, l, x); check("load_4", 32'(l), 32'b1000);
        count_loads(150, n);
        check("full_no_load", 32'(n), 0);
        check("full_visible", 32'(visible), 32'b1111);
        pulse_exceed(4'b0100);
        wait_load(20, l, x); check("refill_slot2", 32'(l), 32'b0100);

        pulse_exceed(4'b1111);
        wait_load(400, l, x); check("after_clear_load", 32'(l), 32'b1000);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        t0 = tick_cnt;
        n  = 0;
        for (int i = 0; i < 400 && (tick_cnt - t0) < 30; i++) begin
            @(negedge clk);
            if (loadX != '0) n++;
        end
        check("frozen_no_load", 32'(n), 0);
        enable = 1'b1;
        wait_load(400, l, x); check("resume_load", 32'(l), 32'b0001);
        wait_load(400, l, x); check("load_slot1", 32'(l), 32'b0010);
        wait_load(400, l, x); check("load_slot2", 32'(l), 32'b0100);

        exceed = 4'b1010;
        @(negedge clk);
        exceed = '0; endLevel = 1'b1;
        check("pre_end_visible", 32'(visible), 32'b0101);
        @(negedge clk);
        endLevel = 1'b0;
        count_loads(80, n);
        check("drain_no_load", 32'(n), 0);
        check("drain_busy", 32'(busy), 1);
        pulse_exceed(4'b0001);
        repeat (3) @(negedge clk);
        pulse_exceed(4'b0100);
        repeat (3) @(negedge clk);
        check("drain_done_busy", 32'(busy), 0);
        check("drain_done_speed", speed, 0);

        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        start_level(4'd5, 32'd7);
        wait_load(400, l, x_first); check("seed5_load1", 32'(l), 32'b0001);
        wait_load(400, l, x);       check("seed5_load2", 32'(l), 32'b0010);
        repeat (3) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_loadX", 32'(loadX), 0);
        check("async_rst_visible", 32'(visible), 0);
        check("async_rst_topLeftX", 32'(topLeftX), 0);
        check("async_rst_speed", speed, 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        start_level(4'd5, 32'd7);
        wait_load(400, l, x); check("repro_load", 32'(l), 32'b0001);
        check("repro_x", 32'(x), 32'(x_first));

        tick_rand = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            startofLevel = ($urandom_range(0, 399) == 0);
            endLevel     = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 19) != 0);
            exceed       = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            if (startofLevel) begin
                seedindex   = 4'($urandom);
                objectSpeed = $urandom;
            end
        end
        @(negedge clk);
        startofLevel = 1'b0; endLevel = 1'b0; exceed = '0; enable = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
